// File: rtl/spi_dac_stream.sv
// spi_dac_stream: SPI master streaming valid/ready words to one of N_CS DACs.
// Configurable word width, SCLK divider, SPI mode, chip-select gap and
// optional CS-held chaining for gapless back-to-back words.
module spi_dac_stream #(
    parameter int WORD_W  = 24,
    parameter int CLK_DIV = 2,
    parameter int MODE    = 0,
    parameter int N_CS    = 1,
    parameter int CS_GAP  = 2,
    localparam int SEL_W  = (N_CS > 1) ? $clog2(N_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WORD_W-1:0] i_data,
    input  logic [SEL_W-1:0]  i_cs_sel,
    input  logic              i_keep_cs,
    output logic              o_busy,
    output logic              o_word_done,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic [N_CS-1:0]   o_cs_n
);

    localparam bit CPOL  = ((MODE / 2) % 2) == 1;
    localparam bit CPHA  = (MODE % 2) == 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_W);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    // LEAD: half-period opened by a leading edge; TRAIL: opened by a trailing edge.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LEAD,
        TRAIL,
        HOLD,
        GAP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WORD_W-1:0] shreg;
    logic              keep;
    logic              armed;
    logic [N_CS-1:0]   cs_active_n;
    logic              tc;
    logic              last_bit;
    logic              chain_slot;
    logic              accept;

    assign tc         = (cnt == CNT_W'(CLK_DIV - 1));
    assign last_bit   = (bit_idx == BIT_W'(WORD_W - 1));
    assign chain_slot = (state == TRAIL) && last_bit && keep && tc;
    assign o_ready    = ((state == IDLE) && armed) || chain_slot;
    assign accept     = i_valid && o_ready;

    // Chip-select pattern for the requested channel; out-of-range selects leave all high.
    always_comb begin
        cs_active_n = '1;
        for (int unsigned i = 0; i < N_CS; i++) begin
            if (N_CS == 1 || i_cs_sel == SEL_W'(i)) begin
                cs_active_n[i] = 1'b0;
            end
        end
    end

    // Frame sequencer: half-period timing, bit shifting, chip selects and registered SPI outputs.
    always_ff @(posedge clk) begin
        o_word_done <= 1'b0;
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            keep    <= 1'b0;
            armed   <= 1'b0;
            o_cs_n  <= '1;
            o_sclk  <= CPOL;
            o_mosi  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (state != IDLE && state != GAP) begin
                cnt <= tc ? '0 : cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg  <= i_data;
                        keep   <= i_keep_cs;
                        o_cs_n <= cs_active_n;
                        o_busy <= 1'b1;
                        cnt    <= '0;
                        state  <= SETUP;
                        if (!CPHA) o_mosi <= i_data[WORD_W-1];
                    end
                end
                SETUP: begin
                    if (tc) begin
                        o_sclk  <= ~CPOL;
                        bit_idx <= '0;
                        state   <= LEAD;
                        if (CPHA) o_mosi <= shreg[WORD_W-1];
                    end
                end
                LEAD: begin
                    if (tc) begin
                        o_sclk <= CPOL;
                        state  <= TRAIL;
                        if (last_bit) begin
                            o_word_done <= 1'b1;
                            // CPHA=0 chaining: the next MSB must already be on MOSI
                            // before the leading edge that coincides with the accept,
                            // so it is taken from the waiting source word here.
                            if (!CPHA && keep) o_mosi <= i_data[WORD_W-1];
                        end else if (!CPHA) begin
                            o_mosi <= shreg[WORD_W-2];
                            shreg  <= shreg << 1;
                        end
                    end
                end
                TRAIL: begin
                    if (tc) begin
                        if (!last_bit) begin
                            o_sclk  <= ~CPOL;
                            bit_idx <= bit_idx + 1'b1;
                            state   <= LEAD;
                            if (CPHA) begin
                                o_mosi <= shreg[WORD_W-2];
                                shreg  <= shreg << 1;
                            end
                        end else if (accept) begin
                            shreg   <= i_data;
                            keep    <= i_keep_cs;
                            o_sclk  <= ~CPOL;
                            bit_idx <= '0;
                            o_mosi  <= i_data[WORD_W-1];
                            state   <= LEAD;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tc) begin
                        o_cs_n  <= '1;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_stream.sv
// Directed testbench for spi_dac_stream: four instances (modes 0..3), a DAC
// sampling model per instance and per-feature test tasks.
module tb_spi_dac_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    logic [3:0]  valid = '0;
    logic [3:0]  keep = '0;
    logic [23:0] data [4];
    logic [2:0]  sel0 = '0;
    wire  [3:0]  ready, busy, wdone, sclk, mosi;
    wire  [4:0]  cs0;
    wire         cs1, cs2, cs3;
    wire  [3:0]  csl = {~cs3, ~cs2, ~cs1, ~&cs0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_dac_stream #(.WORD_W(24), .CLK_DIV(2), .MODE(0), .N_CS(5), .CS_GAP(2)) dut0 (
        .clk(clk), .rst(rst), .i_valid(valid[0]), .o_ready(ready[0]), .i_data(data[0]),
        .i_cs_sel(sel0), .i_keep_cs(keep[0]), .o_busy(busy[0]), .o_word_done(wdone[0]),
        .o_sclk(sclk[0]), .o_mosi(mosi[0]), .o_cs_n(cs0));
    spi_dac_stream #(.WORD_W(24), .CLK_DIV(2), .MODE(1), .N_CS(1), .CS_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .i_valid(valid[1]), .o_ready(ready[1]), .i_data(data[1]),
        .i_cs_sel(1'b0), .i_keep_cs(keep[1]), .o_busy(busy[1]), .o_word_done(wdone[1]),
        .o_sclk(sclk[1]), .o_mosi(mosi[1]), .o_cs_n(cs1));
    spi_dac_stream #(.WORD_W(24), .CLK_DIV(2), .MODE(2), .N_CS(1), .CS_GAP(2)) dut2 (
        .clk(clk), .rst(rst), .i_valid(valid[2]), .o_ready(ready[2]), .i_data(data[2]),
        .i_cs_sel(1'b0), .i_keep_cs(keep[2]), .o_busy(busy[2]), .o_word_done(wdone[2]),
        .o_sclk(sclk[2]), .o_mosi(mosi[2]), .o_cs_n(cs2));
    spi_dac_stream #(.WORD_W(24), .CLK_DIV(2), .MODE(3), .N_CS(1), .CS_GAP(2)) dut3 (
        .clk(clk), .rst(rst), .i_valid(valid[3]), .o_ready(ready[3]), .i_data(data[3]),
        .i_cs_sel(1'b0), .i_keep_cs(keep[3]), .o_busy(busy[3]), .o_word_done(wdone[3]),
        .o_sclk(sclk[3]), .o_mosi(mosi[3]), .o_cs_n(cs3));

    function automatic logic cpol_of(input int m);
        return m[1];
    endfunction
    function automatic logic cpha_of(input int m);
        return m[0];
    endfunction

    // DAC model / monitor state (written only by the monitor)
    int          nlead [4] = '{default: 0};
    int          nwords[4] = '{default: 0};
    int          nwdone[4] = '{default: 0};
    int          nb    [4] = '{default: 0};
    int          last_lead[4] = '{default: -1};
    int          gap_bad [4] = '{default: 0};
    int          idle_bad[4] = '{default: 0};
    logic [23:0] rx    [4];
    logic [23:0] rx_log[256];
    logic [3:0]  psclk = 4'b1100;
    logic [3:0]  pmosi = '0;
    logic        plow0 = 1'b0;
    int          nfall = 0, nrise = 0, low_run = 0, high_run = 1000;
    int          flog[64], hlog[64], llog[64], ldlog[64];
    logic [4:0]  mask_run = '0;
    logic [4:0]  mlog[64];

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (sclk[m] != psclk[m]) begin
                if (sclk[m] != cpol_of(m)) begin
                    nlead[m]++;
                    if (csl[m] && last_lead[m] >= 0 && (cyc - last_lead[m]) != 4) gap_bad[m]++;
                    if (m == 0 && csl[0] && last_lead[0] < 0) ldlog[(nfall - 1) & 63] = cyc;
                    last_lead[m] = cyc;
                end
                if ((sclk[m] != cpol_of(m)) == !cpha_of(m)) begin
                    rx[m] = {rx[m][22:0], pmosi[m]};
                    nb[m]++;
                    if (nb[m] == 24) begin
                        rx_log[m * 64 + (nwords[m] & 63)] = rx[m];
                        nwords[m]++;
                        nb[m] = 0;
                    end
                end
            end
            if (!csl[m]) last_lead[m] = -1;
            if (busy[m] === 1'b0 && sclk[m] !== cpol_of(m)) idle_bad[m]++;
            if (wdone[m] === 1'b1) nwdone[m]++;
            if (rst) nb[m] = 0;
        end
        if (csl[0] === 1'b1) begin
            if (!plow0) begin
                flog[nfall & 63] = cyc;
                hlog[nfall & 63] = high_run;
                nfall++;
                low_run = 0;
                mask_run = '0;
            end
            low_run++;
            mask_run = mask_run | ~cs0;
        end else begin
            if (plow0) begin
                llog[nrise & 63] = low_run;
                mlog[nrise & 63] = mask_run;
                nrise++;
                high_run = 0;
            end
            high_run++;
        end
        plow0 = (csl[0] === 1'b1);
        psclk = sclk;
        pmosi = mosi;
    end

    task automatic send(input int m, input logic [23:0] w, input logic [2:0] s,
                        input logic k, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        valid[m] = 1'b1;
        data[m]  = w;
        keep[m]  = k;
        if (m == 0) sel0 = s;
        while (ready[m] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        checks++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL send_timeout dut%0d: ready never seen, required within 2000 cycles", m);
            valid[m] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            valid[m] = 1'b0;
            keep[m]  = 1'b0;
            data[m]  = ~w;
        end
    endtask

    task automatic wait_idle(input int m);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[m] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL idle_timeout dut%0d: busy still %b, required 0", m, busy[m]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int acc;
        send(0, 24'h123456, 3'd0, 1'b0, acc);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cs0 !== 5'h1f || {cs3, cs2, cs1} !== 3'b111) begin
                fails++;
                $display("FAIL reset_cs: got %h/%b required 1f/111", cs0, {cs3, cs2, cs1});
            end
            checks++;
            if (sclk !== 4'b1100) begin
                fails++;
                $display("FAIL reset_sclk: got %b required 1100", sclk);
            end
            checks++;
            if (mosi !== 4'b0000 || busy !== 4'b0000 || wdone !== 4'b0000 || ready !== 4'b0000) begin
                fails++;
                $display("FAIL reset_flags: mosi=%b busy=%b done=%b ready=%b required all 0",
                         mosi, busy, wdone, ready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 4'b1111) begin
            fails++;
            $display("FAIL reset_ready: got %b required 1111", ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || cs0 !== 5'h1f) begin
            fails++;
            $display("FAIL reset_no_resume: busy=%b cs=%h required 0/1f", busy[0], cs0);
        end
    endtask

    task automatic test_mode0();
        int acc, w0, f0, r0, l0, d0;
        w0 = nwords[0]; f0 = nfall; r0 = nrise; l0 = nlead[0]; d0 = nwdone[0];
        send(0, 24'hA5F00F, 3'd0, 1'b0, acc);
        wait_idle(0);
        checks++;
        if (nwords[0] - w0 != 1 || rx_log[w0 & 63] !== 24'hA5F00F) begin
            fails++;
            $display("FAIL mode0_word: got %0d words, %h required 1, a5f00f", nwords[0] - w0, rx_log[w0 & 63]);
        end
        checks++;
        if (nlead[0] - l0 != 24) begin
            fails++;
            $display("FAIL mode0_edges: got %0d required 24", nlead[0] - l0);
        end
        checks++;
        if (llog[r0 & 63] != 100) begin
            fails++;
            $display("FAIL mode0_cs_low: got %0d required 100", llog[r0 & 63]);
        end
        checks++;
        if (flog[f0 & 63] != acc + 1) begin
            fails++;
            $display("FAIL mode0_cs_fall: got %0d required %0d", flog[f0 & 63], acc + 1);
        end
        checks++;
        if (ldlog[f0 & 63] != acc + 3) begin
            fails++;
            $display("FAIL mode0_first_rise: got %0d required %0d", ldlog[f0 & 63], acc + 3);
        end
        checks++;
        if (nwdone[0] - d0 != 1 || mlog[r0 & 63] !== 5'b00001) begin
            fails++;
            $display("FAIL mode0_done_mask: done=%0d mask=%b required 1, 00001", nwdone[0] - d0, mlog[r0 & 63]);
        end
    endtask

    task automatic test_modes();
        int acc, w0, l0;
        for (int m = 1; m < 4; m++) begin
            w0 = nwords[m]; l0 = nlead[m];
            send(m, 24'h800001, 3'd0, 1'b0, acc);
            wait_idle(m);
            checks++;
            if (nwords[m] - w0 != 1 || rx_log[m * 64 + (w0 & 63)] !== 24'h800001) begin
                fails++;
                $display("FAIL mode%0d_word: got %0d words, %h required 1, 800001",
                         m, nwords[m] - w0, rx_log[m * 64 + (w0 & 63)]);
            end
            checks++;
            if (nlead[m] - l0 != 24) begin
                fails++;
                $display("FAIL mode%0d_edges: got %0d required 24", m, nlead[m] - l0);
            end
            checks++;
            if (idle_bad[m] != 0 || gap_bad[m] != 0) begin
                fails++;
                $display("FAIL mode%0d_sclk_idle: idle_bad=%0d gap_bad=%0d required 0/0", m, idle_bad[m], gap_bad[m]);
            end
        end
    endtask

    task automatic test_chain();
        int acc1, acc2, w0, r0, l0, d0, g0;
        w0 = nwords[0]; r0 = nrise; l0 = nlead[0]; d0 = nwdone[0]; g0 = gap_bad[0];
        send(0, 24'h123456, 3'd0, 1'b1, acc1);
        send(0, 24'h654321, 3'd0, 1'b0, acc2);
        wait_idle(0);
        checks++;
        if (nwords[0] - w0 != 2 || rx_log[w0 & 63] !== 24'h123456 || rx_log[(w0 + 1) & 63] !== 24'h654321) begin
            fails++;
            $display("FAIL chain_words: got %0d words %h %h required 2, 123456 654321",
                     nwords[0] - w0, rx_log[w0 & 63], rx_log[(w0 + 1) & 63]);
        end
        checks++;
        if (nlead[0] - l0 != 48 || gap_bad[0] != g0) begin
            fails++;
            $display("FAIL chain_sclk: edges=%0d uneven=%0d required 48/0", nlead[0] - l0, gap_bad[0] - g0);
        end
        checks++;
        if (nrise - r0 != 1 || llog[r0 & 63] != 196) begin
            fails++;
            $display("FAIL chain_cs: rises=%0d low=%0d required 1/196", nrise - r0, llog[r0 & 63]);
        end
        checks++;
        if (acc2 - acc1 != 98) begin
            fails++;
            $display("FAIL chain_accept: got %0d required 98", acc2 - acc1);
        end
        checks++;
        if (nwdone[0] - d0 != 2) begin
            fails++;
            $display("FAIL chain_done: got %0d required 2", nwdone[0] - d0);
        end
    endtask

    task automatic test_cs_sel();
        int acc, w0, r0, f0, d0;
        w0 = nwords[0]; r0 = nrise; f0 = nfall; d0 = nwdone[0];
        send(0, 24'h0000FF, 3'd2, 1'b0, acc);
        wait_idle(0);
        send(0, 24'hC0FFEE, 3'd5, 1'b0, acc);
        wait_idle(0);
        checks++;
        if (mlog[r0 & 63] !== 5'b00100) begin
            fails++;
            $display("FAIL sel2_mask: got %b required 00100", mlog[r0 & 63]);
        end
        checks++;
        if (nfall - f0 != 1 || nrise - r0 != 1) begin
            fails++;
            $display("FAIL sel5_cs_high: falls=%0d rises=%0d required 1/1", nfall - f0, nrise - r0);
        end
        checks++;
        if (nwdone[0] - d0 != 2 || nwords[0] - w0 != 2) begin
            fails++;
            $display("FAIL sel_done: done=%0d words=%0d required 2/2", nwdone[0] - d0, nwords[0] - w0);
        end
        checks++;
        if (rx_log[w0 & 63] !== 24'h0000FF || rx_log[(w0 + 1) & 63] !== 24'hC0FFEE) begin
            fails++;
            $display("FAIL sel_words: got %h %h required 0000ff c0ffee", rx_log[w0 & 63], rx_log[(w0 + 1) & 63]);
        end
    endtask

    task automatic test_back_to_back();
        int n, w0, f0;
        logic [23:0] words [3];
        words[0] = 24'h0F0F0F; words[1] = 24'hC3C3C3; words[2] = 24'h000001;
        w0 = nwords[0]; f0 = nfall;
        @(negedge clk);
        valid[0] = 1'b1; keep[0] = 1'b0; sel0 = 3'd1; data[0] = words[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (ready[0] !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 2000) begin
                fails++;
                $display("FAIL b2b_timeout: word %0d not accepted within 2000 cycles", k);
            end
            @(posedge clk);
            #1;
            if (k < 2) data[0] = words[k + 1];
            else valid[0] = 1'b0;
        end
        wait_idle(0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx_log[(w0 + k) & 63] !== words[k]) begin
                fails++;
                $display("FAIL b2b_word%0d: got %h required %h", k, rx_log[(w0 + k) & 63], words[k]);
            end
        end
        checks++;
        if (nwords[0] - w0 != 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d required 3", nwords[0] - w0);
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (hlog[(f0 + k) & 63] < 2) begin
                fails++;
                $display("FAIL b2b_gap%0d: got %0d required >= 2", k, hlog[(f0 + k) & 63]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int m = 0; m < 4; m++) data[m] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_mode0();
        test_modes();
        test_chain();
        test_cs_sel();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
